// File: rtl/ula_arbiter.sv
// Round-robin front end that shares one registered-output NRISC_ULA between two requesters.
// One operation in flight at a time: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
module ula_arbiter #(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [TAM-1:0] req0_a,
  input  logic [TAM-1:0] req0_b,
  input  logic [3:0]     req0_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [TAM-1:0] rsp0_data,
  output logic [2:0]     rsp0_flags,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [TAM-1:0] req1_a,
  input  logic [TAM-1:0] req1_b,
  input  logic [3:0]     req1_op,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [TAM-1:0] rsp1_data,
  output logic [2:0]     rsp1_flags,
  output logic [TAM-1:0] ula_a,
  output logic [TAM-1:0] ula_b,
  output logic [3:0]     ula_ctrl,
  input  logic [TAM-1:0] ula_out,
  input  logic [2:0]     ula_flags,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t                  state;
  logic                    last_grant;
  logic                    owner;
  logic [1:0]              gnt;
  logic                    accept;
  logic                    winner;
  logic [1:0]              rsp_valid;
  logic [1:0][TAM-1:0]     rsp_data;
  logic [1:0][2:0]         rsp_flags;
  logic [1:0]              rsp_ready;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt = 2'b00;
    if (req0_valid && !req1_valid)      gnt = 2'b01;
    else if (req1_valid && !req0_valid) gnt = 2'b10;
    else if (req0_valid && req1_valid)  gnt = last_grant ? 2'b01 : 2'b10;
  end

  assign req0_ready = (state == IDLE) && rst && gnt[0];
  assign req1_ready = (state == IDLE) && rst && gnt[1];
  assign accept     = req0_ready || req1_ready;
  assign winner     = req1_ready;
  assign rsp_ready  = {rsp1_ready, rsp0_ready};

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
  assign rsp0_flags = rsp_flags[0];
  assign rsp1_flags = rsp_flags[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_ctrl   <= 4'b0000;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ula_a      <= winner ? req1_a  : req0_a;
          ula_b      <= winner ? req1_b  : req0_b;
          ula_ctrl   <= winner ? req1_op : req0_op;
          owner      <= winner;
          last_grant <= winner;
          busy       <= 1'b1;
          state      <= EXEC;
        end
        EXEC: state <= CAPT;
        // ALU output register is valid here; latch it on the owner's channel.
        CAPT: begin
          rsp_data[owner]  <= ula_out;
          rsp_flags[owner] <= ula_flags;
          rsp_valid[owner] <= 1'b1;
          state            <= RESP;
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid[owner] <= 1'b0;
          busy             <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized bench for ula_arbiter: cycle-level reference model of the grant and
// response protocol plus per-channel scoreboard queues of expected ALU results.
module tb_ula_arbiter;
  localparam int TAM = 16;

  typedef struct packed {
    logic [TAM-1:0] a;
    logic [TAM-1:0] b;
    logic [3:0]     op;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]     vld  = 2'b00;
  logic [1:0]     rrdy = 2'b00;
  logic [TAM-1:0] ta [2];
  logic [TAM-1:0] tb [2];
  logic [3:0]     top [2];

  logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [TAM-1:0] rsp0_data, rsp1_data, ula_a, ula_b, ula_out;
  logic [2:0]     rsp0_flags, rsp1_flags, ula_flags;
  logic [3:0]     ula_ctrl;

  ula_arbiter #(.TAM(TAM)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_a(ta[0]), .req0_b(tb[0]), .req0_op(top[0]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rrdy[0]), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_a(ta[1]), .req1_b(tb[1]), .req1_op(top[1]),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rrdy[1]), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl),
    .ula_out(ula_out), .ula_flags(ula_flags), .busy(busy)
  );

  // Stand-in ALU: {minus, zero, carry} flags, result in low TAM bits.
  function automatic logic [TAM+2:0] alu(input logic [TAM-1:0] a, input logic [TAM-1:0] b,
                                         input logic [3:0] op);
    logic [TAM:0] r;
    case (op)
      4'h0:    r = {1'b0, a} + {1'b0, b};
      4'h1:    r = {1'b0, a} - {1'b0, b};
      4'h2:    r = {1'b0, a & b};
      4'h3:    r = {1'b0, a | b};
      4'h4:    r = {1'b0, a ^ b};
      4'h5:    r = {1'b0, a} + 1;
      default: r = {1'b0, b};
    endcase
    return {r[TAM-1], r[TAM-1:0] == '0, r[TAM], r[TAM-1:0]};
  endfunction

  always_ff @(posedge clk) {ula_flags, ula_out} <= alu(ula_a, ula_b, ula_ctrl);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus: per-channel transaction queues feed a valid/operand driver.
  txn_t     txq [2][$];
  bit       gap_en = 1'b0;
  int       rdy_mode [2] = '{0, 0};
  logic [1:0] hs = 2'b00;

  always @(negedge clk) hs = vld & {req1_ready, req0_ready};

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 2; c++) begin
      if (vld[c] && hs[c]) vld[c] = 1'b0;
      if (!vld[c] && txq[c].size() != 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
        txn_t t;
        t = txq[c].pop_front();
        ta[c] = t.a; tb[c] = t.b; top[c] = t.op;
        vld[c] = 1'b1;
      end
      case (rdy_mode[c])
        0:       rrdy[c] = 1'b1;
        1:       rrdy[c] = 1'($urandom_range(0, 1));
        default: rrdy[c] = 1'b0;
      endcase
    end
  end

  // Reference model: the engine is either free or serving one owner; the owner
  // sees its result three cycles after acceptance and holds it until consumed.
  bit                 m_free = 1'b1;
  int                 m_last = 1;
  int                 m_owner = 0;
  int                 m_age = 0;
  bit                 chk_rst = 1'b0;
  logic [TAM+2:0]     exq [2][$];

  always @(negedge clk) begin
    logic [1:0] er;
    logic [1:0] ev;
    if (chk_rst) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ula_ctrl", 32'(ula_ctrl), 0);
      chk("rst_ula_a", 32'(ula_a), 0);
      chk("rst_ula_b", 32'(ula_b), 0);
      chk("rst_rsp_data", {rsp1_data, rsp0_data}, 0);
      chk("rst_rsp_flags", 32'({rsp1_flags, rsp0_flags}), 0);
      chk_rst = 1'b0;
    end
    er = 2'b00;
    if (rst && m_free) begin
      if (vld == 2'b01 || vld == 2'b10) er = vld;
      else if (vld == 2'b11)            er = (m_last == 1) ? 2'b01 : 2'b10;
    end
    chk("req0_ready", 32'(req0_ready), 32'(er[0]));
    chk("req1_ready", 32'(req1_ready), 32'(er[1]));
    ev = 2'b00;
    if (!m_free && m_age >= 3) ev[m_owner] = 1'b1;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ev[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev[1]));
    chk("busy", 32'(busy), 32'(!m_free));
    for (int c = 0; c < 2; c++) begin
      if (ev[c]) begin
        if (exq[c].size() == 0) begin
          chk("rsp_unexpected", 32'(c), 32'hFFFF_FFFF);
        end else begin
          chk(c ? "rsp1_data" : "rsp0_data", 32'(c ? rsp1_data : rsp0_data), 32'(exq[c][0][TAM-1:0]));
          chk(c ? "rsp1_flags" : "rsp0_flags", 32'(c ? rsp1_flags : rsp0_flags), 32'(exq[c][0][TAM+2:TAM]));
        end
      end
    end
    if (!rst) begin
      m_free = 1'b1; m_last = 1;
      exq[0].delete(); exq[1].delete();
      chk_rst = 1'b1;
    end else if (m_free) begin
      if (er != 2'b00) begin
        m_owner = er[1] ? 1 : 0;
        exq[m_owner].push_back(alu(ta[m_owner], tb[m_owner], top[m_owner]));
        m_free = 1'b0; m_last = m_owner; m_age = 1;
      end
    end else if (m_age >= 3) begin
      if (rrdy[m_owner]) begin
        void'(exq[m_owner].pop_front());
        m_free = 1'b1;
      end
    end else begin
      m_age++;
    end
  end

  task automatic wait_rsp(input int c, input string nm);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (c == 1 ? rsp1_valid : rsp0_valid) break;
    end
    if (n == 200) chk(nm, 0, 1);
  endtask

  task automatic drain(input int limit);
    int n;
    for (n = 0; n < limit; n++) begin
      @(negedge clk);
      if (txq[0].size() == 0 && txq[1].size() == 0 && vld == 2'b00 && m_free) break;
    end
    if (n == limit) chk("drain_timeout", 0, 1);
  endtask

  task automatic push(input int c, input logic [TAM-1:0] a, input logic [TAM-1:0] b,
                      input logic [3:0] op);
    txn_t t;
    t.a = a; t.b = b; t.op = op;
    txq[c].push_back(t);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Single add on requester 0.
    push(0, 16'h0003, 16'h0004, 4'h0);
    wait_rsp(0, "t1_wait");
    chk("t1_data", 32'(rsp0_data), 32'h0007);
    drain(100);

    // Contending requesters, results routed per channel.
    push(0, 16'h1111, 16'h2222, 4'h0); push(0, 16'h8000, 16'h0001, 4'h1);
    push(1, 16'hFFFF, 16'h0001, 4'h0); push(1, 16'h00FF, 16'h0F0F, 4'h4);
    drain(200);

    // Stalled response on requester 1 while requester 0 waits.
    rdy_mode[1] = 2;
    push(1, 16'hF0F0, 16'h3C3C, 4'h2);
    wait_rsp(1, "t3_wait");
    push(0, 16'h0005, 16'h0005, 4'h1);
    repeat (5) @(posedge clk);
    chk("t3_data", 32'(rsp1_data), 32'h3030);
    rdy_mode[1] = 0;
    drain(200);

    // Reset while the ALU is executing; the op must vanish and tie go to requester 0.
    push(0, 16'h1234, 16'h0001, 4'h3);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (vld[0] && req0_ready) break;
    end
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    push(0, 16'h0A0A, 16'h0101, 4'h0);
    push(1, 16'h0B0B, 16'h0101, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_tie_req0", 32'(req0_ready), 1);
    drain(200);

    // Back-to-back increment chain on requester 1 alone.
    for (int i = 1; i <= 4; i++) push(1, 16'(i), 16'h0000, 4'h5);
    drain(200);

    // Random mix with stalls and gaps on both channels.
    gap_en = 1'b1;
    rdy_mode[0] = 1; rdy_mode[1] = 1;
    for (int i = 0; i < 300; i++)
      push(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)));
    drain(20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
